ahbl_slave_responder: RTL and testbench
=======================================

// Module: ahbl_slave_responder
// PURPOSE
// - Drop-in AHB-Lite slave-side responder for formal and sim harnesses: converts free (nondet/random) stimulus into
//   protocol-legal hready/hresp/hexokay/hrdata, so harnesses need no separate slave assumption block per port.
// - Successor to the fixed zero-stall/OKAY tie-offs: adds bounded stall, two-phase ERROR, and exclusive-access monitor
//   (replaces the hexokay=1 tie-off on the CPU data port). One instance per bus port (I and D sides).
// PARAMETERS
// W_ADDR          32   address width
// W_DATA          32   data width
// MAX_BUS_STALL   -1   max consecutive wait states per data phase; -1 = unbounded; 0 = zero-wait
// ERR_EN          1    1: rand_err may produce ERROR responses; 0: OKAY only
// EXCL_EN         1    1: exclusive monitor active; 0: hexokay=1 on every completion of an exclusive transfer
// RESV_LSB        2    reservation granule: address bits [RESV_LSB-1:0] ignored in reservation match
// PORTS
// clk          in   1       clock
// rst_n        in   1       async reset, active low
// haddr        in   W_ADDR  master address phase
// hwrite       in   1       master address phase
// htrans       in   2       master address phase (IDLE=0 BUSY=1 NSEQ=2 SEQ=3)
// hsize        in   3       master address phase (checked for hsize<=log2(W_DATA/8) by bench only)
// hexcl        in   1       exclusive flag, address phase
// hwdata       in   W_DATA  write data, data phase (unused internally; kept for harness visibility)
// rand_stall   in   1       free input: request wait state this cycle
// rand_err     in   1       free input: sampled at end of stall -> ERROR response
// rand_exfail  in   1       free input: force exclusive-write failure when reservation holds
// rand_rdata   in   W_DATA  free input: read data
// hready       out  1       transfer done / bus ready
// hresp        out  1       0 OKAY, 1 ERROR
// hexokay      out  1       exclusive success, valid when hready=1 in exclusive data phase
// hrdata       out  W_DATA  read data
// BEHAVIOUR
// - Reset (async, rst_n=0): state IDLE, hready=1, hresp=0, hexokay=0, hrdata=0, stall_cnt=0, reservation invalid.
// - Address phase accepted when hready=1 & htrans[1]; latch dph_write, dph_excl, dph_addr. IDLE/BUSY never open a data phase.
// - FSM: IDLE (no data phase) -> DPH on accept. DPH: hready=0 while rand_stall & (MAX_BUS_STALL<0 | stall_cnt<MAX_BUS_STALL);
//   else if ERR_EN & rand_err -> ERR1; else hready=1 hresp=0 (completes; next state DPH if new accept, else IDLE).
//   ERR1: hready=0 hresp=1 (one cycle, no stall) -> ERR2. ERR2: hready=1 hresp=1 -> DPH if accept same cycle else IDLE.
// - IDLE: hready=1, hresp=0 combinationally; zero-wait back-to-back pipelining supported (DPH->DPH without IDLE).
// - stall_cnt: +1 per wait state in DPH, cleared on leaving DPH or on new accept; saturates at MAX_BUS_STALL; width
//   $clog2(MAX_BUS_STALL+1), min 1. MAX_BUS_STALL=0: rand_stall ignored.
// - hrdata = rand_rdata when hready=1 & DPH completion & !dph_write; 0 otherwise (incl. ERROR, writes, IDLE).
// - Exclusive (EXCL_EN=1): reservation {valid, addr[W_ADDR-1:RESV_LSB]}.
//   excl read OKAY completion: set valid, load addr; hexokay=1.
//   excl write OKAY completion: hexokay = valid & addr match & !rand_exfail; reservation cleared regardless.
//   any non-excl write OKAY completion to matching granule: clear reservation.
//   ERROR completion: hexokay=0, reservation unchanged.
//   hexokay=0 for non-exclusive completions and whenever hready=0.
// - Simultaneous excl read completion + reservation clear: set wins (new reservation).
// - Output timing: hready/hresp/hexokay/hrdata combinational from state + free inputs; all state registered on clk.
// - Reset mid data phase: outputs return to reset values asynchronously; pending transfer and reservation dropped.
// - Formal: embedded `ifdef FORMAL asserts: hresp=1&hready=1 only in ERR2; ERR1 always precedes ERR2;
//   stall_cnt<=MAX_BUS_STALL; hexokay=0 when hready=0.
// STRUCTURE
// - ahbl_pkg: HTRANS_* / HRESP_* constants, FSM state encodings (IDLE/DPH/ERR1/ERR2).
// - Sub-module ahbl_excl_monitor (reservation reg, match, set/clear priority); instantiated if EXCL_EN else tied.
// - Top: address-phase latch, FSM, stall counter, output mux.
// TESTING
// 1. Reset release, htrans=IDLE 10 cycles -> hready=1, hresp=0, hexokay=0, hrdata=0 every cycle.
// 2. MAX_BUS_STALL=3, NSEQ read @0x100, rand_stall=1 held -> exactly 3 cycles hready=0, then hready=1, hrdata=rand_rdata.
// 3. ERR_EN=1, NSEQ write, rand_err=1 -> cycle1 hready=0 hresp=1; cycle2 hready=1 hresp=1; master IDLE -> FSM IDLE.
// 4. Excl read @0x204 OKAY, excl write @0x206 (RESV_LSB=2) rand_exfail=0 -> hexokay=1; repeat write -> hexokay=0.
// 5. Excl read @0x300, plain write @0x300, excl write @0x300 -> final hexokay=0; excl read+ERROR -> no reservation.
// 6. Back-to-back NSEQ x4 zero stall -> 4 completions in 5 cycles; assert rst_n=0 mid-stall -> hready=1 immediately.

Source files
------------

// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite encodings and responder FSM states.
package ahbl_pkg;

  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_BUSY = 2'b01;
  localparam logic [1:0] HTRANS_NSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ  = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // IDLE: no data phase open; DPH: data phase (may stall);
  // ERR1/ERR2: first and second cycle of the two-cycle ERROR response.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DPH  = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } ahbl_state_e;

  // Stall counter width; unbounded (<0) and zero-wait (0) still get one bit.
  function automatic int stallCntWidth(input int maxStall);
    return (maxStall <= 0) ? 1 : $clog2(maxStall + 1);
  endfunction

endpackage

// File: rtl/ahbl_excl_monitor.sv
// Single-entry exclusive-access reservation monitor for one bus port.
module ahbl_excl_monitor
  import ahbl_pkg::*;
#(
  parameter int W_ADDR   = 32,
  parameter int RESV_LSB = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_complete,
  input  logic              i_write,
  input  logic              i_excl,
  input  logic [W_ADDR-1:0] i_addr,
  input  logic              i_rand_exfail,
  output logic              o_exokay
);

  localparam int W_TAG = W_ADDR - RESV_LSB;

  logic             r_valid;
  logic [W_TAG-1:0] r_tag;
  logic             w_match;
  logic             w_set;
  logic             w_clr;
  logic             w_unusedLsb;

  assign w_match = r_valid & (i_addr[W_ADDR-1:RESV_LSB] == r_tag);

  // An exclusive read opens a reservation; an exclusive write always consumes
  // it, and a plain write to the reserved granule kills it.
  assign w_set = i_complete & i_excl & ~i_write;
  assign w_clr = i_complete & i_write & (i_excl | w_match);

  // Exclusive reads always succeed; exclusive writes need a live matching
  // reservation and no injected failure.
  assign o_exokay = i_complete & i_excl & (~i_write | (w_match & ~i_rand_exfail));

  generate
    if (RESV_LSB > 0) begin : g_lsb
      assign w_unusedLsb = ^i_addr[RESV_LSB-1:0];
    end else begin : g_noLsb
      assign w_unusedLsb = 1'b0;
    end
  endgenerate

  // Reservation register; a set in the same cycle as a clear takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
    end else if (w_set) begin
      r_valid <= 1'b1;
      r_tag   <= i_addr[W_ADDR-1:RESV_LSB];
    end else if (w_clr) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ahbl_slave_responder.sv
// AHB-Lite slave-side responder: turns free stimulus into legal
// hready/hresp/hexokay/hrdata with bounded stalls and two-cycle ERROR.
module ahbl_slave_responder
  import ahbl_pkg::*;
#(
  parameter int W_ADDR        = 32,
  parameter int W_DATA        = 32,
  parameter int MAX_BUS_STALL = -1,
  parameter bit ERR_EN        = 1'b1,
  parameter bit EXCL_EN       = 1'b1,
  parameter int RESV_LSB      = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [W_ADDR-1:0] i_haddr,
  input  logic              i_hwrite,
  input  logic [1:0]        i_htrans,
  input  logic [2:0]        i_hsize,
  input  logic              i_hexcl,
  input  logic [W_DATA-1:0] i_hwdata,
  input  logic              i_rand_stall,
  input  logic              i_rand_err,
  input  logic              i_rand_exfail,
  input  logic [W_DATA-1:0] i_rand_rdata,
  output logic              o_hready,
  output logic              o_hresp,
  output logic              o_hexokay,
  output logic [W_DATA-1:0] o_hrdata
);

  localparam int W_STALL = stallCntWidth(MAX_BUS_STALL);

  ahbl_state_e        r_state;
  ahbl_state_e        w_nextState;
  logic [W_STALL-1:0] r_stallCnt;
  logic               r_dphWrite;
  logic               r_dphExcl;
  logic [W_ADDR-1:0]  r_dphAddr;

  logic w_hready;
  logic w_hresp;
  logic w_complete;
  logic w_stallInc;
  logic w_goErr;
  logic w_stallAllowed;
  logic w_accept;
  logic w_unused;

  // Write data and transfer size only matter to the harness, not to the response.
  assign w_unused = ^{i_hwdata, i_hsize, i_htrans[0]};

  assign w_stallAllowed = (MAX_BUS_STALL < 0) ? 1'b1
                        : (int'(r_stallCnt) < MAX_BUS_STALL);

  // Response outputs from state and free inputs; an OKAY completion is
  // hready high in a data phase.
  always_comb begin
    w_hready   = 1'b1;
    w_hresp    = HRESP_OKAY;
    w_complete = 1'b0;
    w_stallInc = 1'b0;
    w_goErr    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_hready = 1'b1;
      end
      ST_DPH: begin
        if (i_rand_stall && w_stallAllowed) begin
          w_hready   = 1'b0;
          w_stallInc = 1'b1;
        end else if (ERR_EN && i_rand_err) begin
          w_hready = 1'b0;
          w_goErr  = 1'b1;
        end else begin
          w_complete = 1'b1;
        end
      end
      ST_ERR1: begin
        w_hready = 1'b0;
        w_hresp  = HRESP_ERROR;
      end
      ST_ERR2: begin
        w_hready = 1'b1;
        w_hresp  = HRESP_ERROR;
      end
      default: begin
        w_hready = 1'b1;
      end
    endcase
  end

  assign w_accept = w_hready & i_htrans[1];

  // Next-state logic; any cycle with hready high may open a new data phase.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: w_nextState = w_accept ? ST_DPH : ST_IDLE;
      ST_DPH: begin
        if (w_goErr)          w_nextState = ST_ERR1;
        else if (w_stallInc)  w_nextState = ST_DPH;
        else                  w_nextState = w_accept ? ST_DPH : ST_IDLE;
      end
      ST_ERR1: w_nextState = ST_ERR2;
      ST_ERR2: w_nextState = w_accept ? ST_DPH : ST_IDLE;
      default: w_nextState = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_nextState;
  end

  // Wait-state counter: counts consecutive stalls, cleared by anything else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             r_stallCnt <= '0;
    else if (w_stallInc && MAX_BUS_STALL > 0) r_stallCnt <= r_stallCnt + 1'b1;
    else                                    r_stallCnt <= '0;
  end

  // Capture the address-phase attributes of each accepted transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dphWrite <= 1'b0;
      r_dphExcl  <= 1'b0;
      r_dphAddr  <= '0;
    end else if (w_accept) begin
      r_dphWrite <= i_hwrite;
      r_dphExcl  <= i_hexcl;
      r_dphAddr  <= i_haddr;
    end
  end

  generate
    if (EXCL_EN) begin : g_excl
      ahbl_excl_monitor #(
        .W_ADDR   (W_ADDR),
        .RESV_LSB (RESV_LSB)
      ) u_exclMonitor (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_complete    (w_complete),
        .i_write       (r_dphWrite),
        .i_excl        (r_dphExcl),
        .i_addr        (r_dphAddr),
        .i_rand_exfail (i_rand_exfail),
        .o_exokay      (o_hexokay)
      );
    end else begin : g_noExcl
      logic w_unusedExcl;
      assign w_unusedExcl = ^{r_dphAddr, i_rand_exfail};
      assign o_hexokay    = w_complete & r_dphExcl;
    end
  endgenerate

  assign o_hready = w_hready;
  assign o_hresp  = w_hresp;
  assign o_hrdata = (w_complete && !r_dphWrite) ? i_rand_rdata : '0;

`ifdef FORMAL
  // Protocol properties on the generated response.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(o_hresp && o_hready) || r_state == ST_ERR2);
      assert (MAX_BUS_STALL < 0 || int'(r_stallCnt) <= MAX_BUS_STALL);
      assert (o_hready || !o_hexokay);
    end
  end

  a_err1BeforeErr2: assert property (@(posedge clk) disable iff (!rst_n)
    (r_state == ST_ERR2) |-> $past(r_state) == ST_ERR1);
`endif

endmodule

// File: tb/tb_ahbl_slave_responder.sv
// Directed self-checking bench for ahbl_slave_responder.
module tb_ahbl_slave_responder;
  import ahbl_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] i_haddr;
  logic        i_hwrite;
  logic [1:0]  i_htrans;
  logic [2:0]  i_hsize;
  logic        i_hexcl;
  logic [31:0] i_hwdata;
  logic        i_rand_stall;
  logic        i_rand_err;
  logic        i_rand_exfail;
  logic [31:0] i_rand_rdata;
  logic        o_hready;
  logic        o_hresp;
  logic        o_hexokay;
  logic [31:0] o_hrdata;

  int checkCount;
  int errorCount;
  int doneCount;

  ahbl_slave_responder #(
    .W_ADDR        (32),
    .W_DATA        (32),
    .MAX_BUS_STALL (3),
    .ERR_EN        (1'b1),
    .EXCL_EN       (1'b1),
    .RESV_LSB      (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_haddr       (i_haddr),
    .i_hwrite      (i_hwrite),
    .i_htrans      (i_htrans),
    .i_hsize       (i_hsize),
    .i_hexcl       (i_hexcl),
    .i_hwdata      (i_hwdata),
    .i_rand_stall  (i_rand_stall),
    .i_rand_err    (i_rand_err),
    .i_rand_exfail (i_rand_exfail),
    .i_rand_rdata  (i_rand_rdata),
    .o_hready      (o_hready),
    .o_hresp       (o_hresp),
    .o_hexokay     (o_hexokay),
    .o_hrdata      (o_hrdata)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of inputs just after the rising edge, then move to the
  // falling edge where the combinational outputs are sampled.
  task automatic applyStimulus(input logic [1:0] trans, input logic [31:0] addr,
                               input logic write, input logic excl,
                               input logic stall, input logic err,
                               input logic exfail, input logic [31:0] rdata);
    @(posedge clk);
    #1;
    i_htrans      = trans;
    i_haddr       = addr;
    i_hwrite      = write;
    i_hexcl       = excl;
    i_hwdata      = addr ^ 32'h5A5A_5A5A;
    i_rand_stall  = stall;
    i_rand_err    = err;
    i_rand_exfail = exfail;
    i_rand_rdata  = rdata;
    #4;
  endtask

  task automatic checkOutput(input string tag, input logic expReady,
                             input logic expResp, input logic expExokay,
                             input logic [31:0] expRdata);
    checkCount++;
    assert (o_hready === expReady) else begin
      errorCount++;
      $error("[TB] FAIL %s hready got %0b expected %0b", tag, o_hready, expReady);
    end
    checkCount++;
    assert (o_hresp === expResp) else begin
      errorCount++;
      $error("[TB] FAIL %s hresp got %0b expected %0b", tag, o_hresp, expResp);
    end
    checkCount++;
    assert (o_hexokay === expExokay) else begin
      errorCount++;
      $error("[TB] FAIL %s hexokay got %0b expected %0b", tag, o_hexokay, expExokay);
    end
    checkCount++;
    assert (o_hrdata === expRdata) else begin
      errorCount++;
      $error("[TB] FAIL %s hrdata got %h expected %h", tag, o_hrdata, expRdata);
    end
  endtask

  // Directed sequence covering reset, stalls, errors, exclusives, pipelining.
  initial begin
    checkCount    = 0;
    errorCount    = 0;
    doneCount     = 0;
    rst_n         = 1'b0;
    i_htrans      = HTRANS_IDLE;
    i_haddr       = '0;
    i_hwrite      = 1'b0;
    i_hsize       = 3'd2;
    i_hexcl       = 1'b0;
    i_hwdata      = '0;
    i_rand_stall  = 1'b1;
    i_rand_err    = 1'b0;
    i_rand_exfail = 1'b0;
    i_rand_rdata  = 32'hDEAD_BEEF;
    #3;
    checkOutput("reset", 1'b1, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    $display("[TB] idle after reset");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(HTRANS_IDLE, 32'h0, 1'b0, 1'b0, i[0], i[1], 1'b0, 32'h1234_0000 + i);
      checkOutput("idle", 1'b1, 1'b0, 1'b0, 32'h0);
    end

    $display("[TB] bounded stall");
    applyStimulus(HTRANS_NSEQ, 32'h100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1);
    checkOutput("t2_addr", 1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(HTRANS_IDLE, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hA5A5_0001);
      checkOutput("t2_wait", 1'b0, 1'b0, 1'b0, 32'h0);
    end
    applyStimulus(HTRANS_IDLE, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hA5A5_0001);
    checkOutput("t2_done", 1'b1, 1'b0, 1'b0, 32'hA5A5_0001);
    applyStimulus(HTRANS_IDLE, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hA5A5_0002);
    checkOutput("t2_idle", 1'b1, 1'b0, 1'b0, 32'h0);

    $display("[TB] two-cycle error");
    applyStimulus(HTRANS_NSEQ, 32'h40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1111);
    checkOutput("t3_addr", 1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(HTRANS_IDLE, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h2222);
    checkOutput("t3_errdec", 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(HTRANS_IDLE, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h2222);
    checkOutput("t3_err1", 1'b0, 1'b1, 1'b0, 32'h0);
    applyStimulus(HTRANS_IDLE, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h2222);
    checkOutput("t3_err2", 1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(HTRANS_IDLE, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h2222);
    checkOutput("t3_idle", 1'b1, 1'b0, 1'b0, 32'h0);

    $display("[TB] exclusive pair in one granule");
    applyStimulus(HTRANS_NSEQ, 32'h204, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h44);
    checkOutput("t4_addr", 1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(HTRANS_NSEQ, 32'h206, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h4444);
    checkOutput("t4_exrd", 1'b1, 1'b0, 1'b1, 32'h4444);
    applyStimulus(HTRANS_NSEQ, 32'h206, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h55);
    checkOutput("t4_exwr1", 1'b1, 1'b0, 1'b1, 32'h0);
    applyStimulus(HTRANS_IDLE, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h55);
    checkOutput("t4_exwr2", 1'b1, 1'b0, 1'b0, 32'h0);

    $display("[TB] reservation killed by plain write");
    applyStimulus(HTRANS_NSEQ, 32'h300, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("t5_addr", 1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(HTRANS_NSEQ, 32'h300, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h3030);
    checkOutput("t5_exrd", 1'b1, 1'b0, 1'b1, 32'h3030);
    applyStimulus(HTRANS_NSEQ, 32'h300, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h3030);
    checkOutput("t5_plainwr", 1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(HTRANS_IDLE, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h3030);
    checkOutput("t5_exwr", 1'b1, 1'b0, 1'b0, 32'h0);

    $display("[TB] exclusive read with error sets no reservation");
    applyStimulus(HTRANS_NSEQ, 32'h400, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("t5e_addr", 1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(HTRANS_IDLE, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h4040);
    checkOutput("t5e_errdec", 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(HTRANS_IDLE, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h4040);
    checkOutput("t5e_err1", 1'b0, 1'b1, 1'b0, 32'h0);
    applyStimulus(HTRANS_NSEQ, 32'h400, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h4040);
    checkOutput("t5e_err2", 1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(HTRANS_IDLE, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h4040);
    checkOutput("t5e_exwr", 1'b1, 1'b0, 1'b0, 32'h0);

    $display("[TB] injected exclusive failure");
    applyStimulus(HTRANS_NSEQ, 32'h500, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("t5f_addr", 1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(HTRANS_NSEQ, 32'h500, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h5);
    checkOutput("t5f_exrd", 1'b1, 1'b0, 1'b1, 32'h5);
    applyStimulus(HTRANS_IDLE, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h5);
    checkOutput("t5f_exwr", 1'b1, 1'b0, 1'b0, 32'h0);

    $display("[TB] back-to-back pipelined reads");
    applyStimulus(HTRANS_NSEQ, 32'h600, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("t6_addr", 1'b1, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus((k < 3) ? HTRANS_SEQ : HTRANS_IDLE, 32'h604 + 32'(4 * k),
                    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hB000_0000 + k);
      if (o_hready === 1'b1) doneCount++;
      checkOutput("t6_b2b", 1'b1, 1'b0, 1'b0, 32'hB000_0000 + k);
    end
    checkCount++;
    assert (doneCount === 4) else begin
      errorCount++;
      $error("[TB] FAIL t6_count completions got %0d expected 4", doneCount);
    end

    $display("[TB] reset during stall");
    applyStimulus(HTRANS_NSEQ, 32'h800, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("t6r_addr", 1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(HTRANS_NSEQ, 32'h700, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h88);
    checkOutput("t6r_exrd", 1'b1, 1'b0, 1'b1, 32'h88);
    applyStimulus(HTRANS_IDLE, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h77);
    checkOutput("t6r_stall", 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("t6r_rst", 1'b1, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    applyStimulus(HTRANS_NSEQ, 32'h800, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h99);
    checkOutput("t6r_post", 1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(HTRANS_IDLE, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h99);
    checkOutput("t6r_resvdrop", 1'b1, 1'b0, 1'b0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
